// File: rtl/multi_interval_timer_if.sv
// Avalon-MM 16-bit slave bus bundle for the multi-channel interval timer.
// Master drives address/strobes/data, slave returns registered readdata.
interface multi_interval_timer_if #(
   parameter int ADDR_W = 6
);
   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              write_n;
   logic [15:0]       writedata;
   logic [15:0]       readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );
endinterface

// File: rtl/multi_interval_timer.sv
// NUM_CH independent down-counting interval timers with prescalers,
// snapshots, a global start/pending page and a combined irq.
module multi_interval_timer #(
   parameter int NUM_CH       = 4,
   parameter int COUNT_W      = 32,
   parameter int PS_W         = 16,
   parameter int PERIOD_RESET = 99999,
   parameter int ADDR_W       = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   multi_interval_timer_if.slave bus,
   output logic                  irq,
   output logic [NUM_CH-1:0]     ch_timeout
);
   localparam int PG_W = ADDR_W - 3;
   localparam int HI_W = COUNT_W - 16;

   logic              wr;
   logic              glb_wr;
   logic [PG_W-1:0]   page;
   logic [2:0]        rsel;
   logic [15:0]       wd;

   logic [COUNT_W-1:0] count_q  [NUM_CH];
   logic [COUNT_W-1:0] period_q [NUM_CH];
   logic [COUNT_W-1:0] snap_q   [NUM_CH];
   logic [PS_W-1:0]    ps_q     [NUM_CH];
   logic [PS_W-1:0]    psc_q    [NUM_CH];

   logic [NUM_CH-1:0] to_q, run_q, roe_q;
   logic [NUM_CH-1:0] ito_q, cont_q;
   logic [NUM_CH-1:0] reload_q, tout_q;
   logic [15:0]       rdata_q, rdata_d;

   logic [NUM_CH-1:0] sel, start, stop;
   logic [NUM_CH-1:0] per_wr, stat_wr;
   logic [NUM_CH-1:0] tick, ev, pend;

   assign wr     = bus.chipselect & ~bus.write_n;
   assign page   = bus.address[ADDR_W-1:3];
   assign rsel   = bus.address[2:0];
   assign wd     = bus.writedata;
   assign glb_wr = wr && (page == PG_W'(NUM_CH));

   // Per-channel write strobes, prescaler ticks and timeout events
   always_comb begin
      sel     = '0;
      start   = '0;
      stop    = '0;
      per_wr  = '0;
      stat_wr = '0;
      tick    = '0;
      ev      = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         sel[i]     = wr && (page == PG_W'(i));
         start[i]   = (sel[i] && rsel == 3'd1 && wd[2])
                    || (glb_wr && rsel == 3'd1 && wd[i]);
         stop[i]    = sel[i] && rsel == 3'd1 && wd[3];
         per_wr[i]  = sel[i] && (rsel == 3'd2 || rsel == 3'd3);
         stat_wr[i] = sel[i] && rsel == 3'd0;
         tick[i]    = run_q[i] && (psc_q[i] == '0);
         ev[i]      = tick[i] && (count_q[i] == '0);
      end
   end

   assign pend       = to_q & ito_q;
   assign irq        = |pend;
   assign ch_timeout = tout_q;
   assign bus.readdata = rdata_q;

   // Read mux; registered below for one-cycle read latency
   always_comb begin
      rdata_d = '0;
      if (page == PG_W'(NUM_CH)) begin
         if (rsel == 3'd0) rdata_d = 16'(pend);
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (page == PG_W'(i)) begin
               case (rsel)
                  3'd0: rdata_d = 16'({roe_q[i], run_q[i], to_q[i]});
                  3'd1: rdata_d = 16'({cont_q[i], ito_q[i]});
                  3'd2: rdata_d = period_q[i][15:0];
                  3'd3: rdata_d = 16'(period_q[i][COUNT_W-1:16]);
                  3'd4: rdata_d = snap_q[i][15:0];
                  3'd5: rdata_d = 16'(snap_q[i][COUNT_W-1:16]);
                  3'd6: rdata_d = 16'(ps_q[i]);
                  default: rdata_d = '0;
               endcase
            end
         end
      end
   end

   // Channel state, register file and read data
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q  <= '0;
         to_q     <= '0;
         run_q    <= '0;
         roe_q    <= '0;
         ito_q    <= '0;
         cont_q   <= '0;
         reload_q <= '0;
         tout_q   <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            count_q[i]  <= COUNT_W'(PERIOD_RESET);
            period_q[i] <= COUNT_W'(PERIOD_RESET);
            snap_q[i]   <= '0;
            ps_q[i]     <= '0;
            psc_q[i]    <= '0;
         end
      end else begin
         rdata_q <= rdata_d;
         for (int i = 0; i < NUM_CH; i++) begin
            tout_q[i]   <= ev[i];
            reload_q[i] <= per_wr[i];

            if (reload_q[i] || ev[i])
               count_q[i] <= period_q[i];
            else if (tick[i])
               count_q[i] <= count_q[i] - 1'b1;

            // Prescaler sits at PRESCALE when idle; a START restarts it
            if (reload_q[i] || !run_q[i] || start[i] || tick[i])
               psc_q[i] <= ps_q[i];
            else
               psc_q[i] <= psc_q[i] - 1'b1;

            if (per_wr[i])
               run_q[i] <= 1'b0;
            else if (start[i])
               run_q[i] <= 1'b1;
            else if (stop[i] || (ev[i] && !cont_q[i]))
               run_q[i] <= 1'b0;

            // A timeout wins over a simultaneous status clear
            if (ev[i])
               to_q[i] <= 1'b1;
            else if (stat_wr[i])
               to_q[i] <= 1'b0;

            if (stat_wr[i])
               roe_q[i] <= 1'b0;
            else if (ev[i] && to_q[i])
               roe_q[i] <= 1'b1;

            if (sel[i] && rsel == 3'd1) begin
               ito_q[i]  <= wd[0];
               cont_q[i] <= wd[1];
            end
            if (sel[i] && rsel == 3'd2)
               period_q[i][15:0] <= wd;
            if (sel[i] && rsel == 3'd3)
               period_q[i][COUNT_W-1:16] <= wd[HI_W-1:0];
            if (sel[i] && (rsel == 3'd4 || rsel == 3'd5))
               snap_q[i] <= count_q[i];
            if (sel[i] && rsel == 3'd6)
               ps_q[i] <= wd[PS_W-1:0];
         end
      end
   end
endmodule
